// File: rtl/pe_conv_pkg.sv
// Shared definitions for the convolution processing element: parameter
// defaults, accumulator sizing and a signed saturation helper.
package pe_conv_pkg;

  localparam int DW_DEF   = 8;   // ifmap width, unsigned
  localparam int WW_DEF   = 8;   // weight width, signed
  localparam int TAPS_DEF = 3;   // taps per PE, 1..8
  localparam int PW_DEF   = 20;  // psum width, signed

  // Accumulator wide enough for psum_in plus TAPS products without overflow.
  function automatic int acc_width(input int pw, input int taps);
    return pw + $clog2(taps + 1) + 1;
  endfunction

  localparam int ACC_W_DEF = acc_width(PW_DEF, TAPS_DEF);

  // Clamp a signed value of in_w bits (held in the low bits of v) into the
  // signed range of out_w bits. The result is sign-extended to 64 bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned    in_w,
                                                    input int unsigned    out_w);
    logic signed [63:0] v_ext;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v_ext = (v <<< (64 - in_w)) >>> (64 - in_w);
    hi    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (out_w - 1));
    if (v_ext > hi)      return hi;
    else if (v_ext < lo) return lo;
    else                 return v_ext;
  endfunction

endpackage

// File: rtl/pe_conv_param_if.sv
// Data/handshake bundle of the convolution PE. The PE is the slave; the
// driver (upstream logic or a bench) is the master.
interface pe_conv_param_if
  import pe_conv_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int WW   = WW_DEF,
  parameter int TAPS = TAPS_DEF,
  parameter int PW   = PW_DEF
);
  logic                 en;
  logic                 ifmap_vld;
  logic [DW-1:0]        ifmap_in;
  logic                 win_clr;
  logic [DW-1:0]        ifmap_out;
  logic                 w_load;
  logic [TAPS*WW-1:0]   w_in;
  logic [TAPS*WW-1:0]   w_out;
  logic                 psum_in_vld;
  logic [PW-1:0]        psum_in;
  logic                 psum_out_vld;
  logic [PW-1:0]        psum_out;
  logic                 ovf;
  logic                 clr_ovf;

  modport slave (
    input  en, ifmap_vld, ifmap_in, win_clr, w_load, w_in,
           psum_in_vld, psum_in, clr_ovf,
    output ifmap_out, w_out, psum_out_vld, psum_out, ovf
  );

  modport master (
    output en, ifmap_vld, ifmap_in, win_clr, w_load, w_in,
           psum_in_vld, psum_in, clr_ovf,
    input  ifmap_out, w_out, psum_out_vld, psum_out, ovf
  );
endinterface

// File: rtl/pe_tap_shift.sv
// Tap shift register and window fill counter. Exposes the post-accept tap
// values and fill state so the multiplier stage can register products on
// the accepting edge.
module pe_tap_shift
  import pe_conv_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int TAPS = TAPS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     vld_i,
  input  logic [DW-1:0]            data_i,
  input  logic                     win_clr_i,
  output logic [DW-1:0]            tap0_o,
  output logic [TAPS-1:0][DW-1:0]  taps_nxt_o,
  output logic                     full_nxt_o
);
  localparam int CW = $clog2(TAPS + 1);

  logic [TAPS-1:0][DW-1:0] taps_q, taps_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    accept;

  assign accept = en_i && vld_i;

  // Next tap contents and fill count.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    taps_d = taps_q;
    cnt_d  = cnt_q;
    if (accept) begin
      taps_d[0] = data_i;
      for (int k = 1; k < TAPS; k++) taps_d[k] = taps_q[k-1];
    end
    if (en_i && win_clr_i) begin
      cnt_d = accept ? CW'(1) : '0;
    end else if (accept && (cnt_q != CW'(TAPS))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Tap and counter state; the _d values already hold when not advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      taps_q <= '0;
      cnt_q  <= '0;
    end else begin
      taps_q <= taps_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tap0_o     = taps_q[0];
  assign taps_nxt_o = taps_d;
  assign full_nxt_o = (cnt_d == CW'(TAPS));

endmodule

// File: rtl/pe_conv_param.sv
// Convolution processing element: TAPS-deep ifmap window times signed
// weights, added to an upstream partial sum in a two-stage pipeline.
// Optional build macro PE_SATURATE_EN: clamp the result to PW bits and
// raise a sticky ovf; otherwise the result wraps and ovf is tied low.
module pe_conv_param
  import pe_conv_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int WW   = WW_DEF,
  parameter int TAPS = TAPS_DEF,
  parameter int PW   = PW_DEF
) (
  input logic              clk,
  input logic              rst_n,
  pe_conv_param_if.slave   bus
);
  localparam int PRW   = DW + WW + 1;
  localparam int ACC_W = acc_width(PW, TAPS);

  logic                     accept;
  logic                     full_nxt;
  logic [TAPS-1:0][DW-1:0]  taps_nxt;
  logic [DW-1:0]            tap0;

  logic [TAPS*WW-1:0]       w_q;

  logic signed [PRW-1:0]    prod_d [TAPS];
  logic signed [PRW-1:0]    prod_q [TAPS];
  logic signed [PW-1:0]     s1_psum_q;
  logic                     s1_vld_q;

  logic signed [ACC_W-1:0]  sum;
  logic [PW-1:0]            psum_nxt;
  logic [PW-1:0]            psum_out_q;
  logic                     psum_out_vld_q;

  assign accept = bus.en && bus.ifmap_vld;

  pe_tap_shift #(
    .DW   (DW),
    .TAPS (TAPS)
  ) u_taps (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (bus.en),
    .vld_i      (bus.ifmap_vld),
    .data_i     (bus.ifmap_in),
    .win_clr_i  (bus.win_clr),
    .tap0_o     (tap0),
    .taps_nxt_o (taps_nxt),
    .full_nxt_o (full_nxt)
  );

  // Active weights; a sample accepted alongside a load still sees the old set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    w_q <= '0;
    else if (bus.en && bus.w_load) w_q <= bus.w_in;
  end

  // Products of the post-accept taps with the current weights.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod_d[k] = $signed({1'b0, taps_nxt[k]}) * $signed(w_q[k*WW +: WW]);
    end
  end

  // Stage 1: capture products and upstream psum when a full window is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
      s1_psum_q <= '0;
      s1_vld_q  <= 1'b0;
    end else if (bus.en) begin
      s1_vld_q <= accept && full_nxt;
      if (accept && full_nxt) begin
        for (int k = 0; k < TAPS; k++) prod_q[k] <= prod_d[k];
        s1_psum_q <= bus.psum_in_vld ? $signed(bus.psum_in) : '0;
      end
    end
  end

  // Full-precision adder tree.
  always_comb begin
    sum = ACC_W'(s1_psum_q);
    for (int k = 0; k < TAPS; k++) sum = sum + ACC_W'(prod_q[k]);
  end

`ifdef PE_SATURATE_EN
  logic signed [63:0] sum_ext;
  logic signed [63:0] sat_v;
  logic               clamp;
  logic               ovf_q;

  // Clamp the sum into PW bits and flag when clamping happened.
  always_comb begin
    sum_ext  = 64'(sum);
    sat_v    = sat_signed(sum_ext, ACC_W, PW);
    clamp    = (sat_v != sum_ext);
    psum_nxt = sat_v[PW-1:0];
  end

  wire unused_sat_hi = &{1'b0, sat_v[63:PW]};

  // Sticky overflow: a new clamp wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.en) begin
      if (s1_vld_q && clamp) ovf_q <= 1'b1;
      else if (bus.clr_ovf)  ovf_q <= 1'b0;
    end
  end

  assign bus.ovf = ovf_q;
`else
  // Wrap: keep the low PW bits of the sum.
  assign psum_nxt = sum[PW-1:0];
  assign bus.ovf  = 1'b0;

  wire unused_wrap = &{1'b0, sum[ACC_W-1:PW], bus.clr_ovf};
`endif

  // Stage 2: result register; holds its value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_out_q     <= '0;
      psum_out_vld_q <= 1'b0;
    end else if (bus.en) begin
      psum_out_vld_q <= s1_vld_q;
      if (s1_vld_q) psum_out_q <= psum_nxt;
    end
  end

  assign bus.ifmap_out    = tap0;
  assign bus.w_out        = w_q;
  assign bus.psum_out     = psum_out_q;
  assign bus.psum_out_vld = psum_out_vld_q;

endmodule

// File: tb/tb_pe_conv_param.sv
// Directed bench for pe_conv_param at default parameters. Expected values
// are hand-computed; the overflow expectation follows PE_SATURATE_EN.
module tb_pe_conv_param;
  import pe_conv_pkg::*;

  localparam logic [23:0] W_321 = 24'h03FE01;  // tap2=3, tap1=-2, tap0=1
  localparam logic [23:0] W_111 = 24'h010101;
  localparam logic [23:0] W_127 = 24'h7F7F7F;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  pe_conv_param_if #(.DW(8), .WW(8), .TAPS(3), .PW(20)) bus ();

  pe_conv_param #(.DW(8), .WW(8), .TAPS(3), .PW(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] ps(input int v);
    logic [19:0] t;
    t = v[19:0];
    return {12'b0, t};
  endfunction

  function automatic logic [31:0] po();
    return {12'b0, bus.psum_out};
  endfunction

  // Drive one cycle of inputs, clock it, and return 1 time unit after the edge.
  task automatic step(input logic e, input logic v, input logic [7:0] d,
                      input logic clr, input logic wl, input logic [23:0] w,
                      input logic co);
    bus.en        = e;
    bus.ifmap_vld = v;
    bus.ifmap_in  = d;
    bus.win_clr   = clr;
    bus.w_load    = wl;
    bus.w_in      = w;
    bus.clr_ovf   = co;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ovf_psum_exp;
    logic        ovf_exp;
`ifdef PE_SATURATE_EN
    ovf_psum_exp = ps(524287);
    ovf_exp      = 1'b1;
`else
    ovf_psum_exp = ps(621433);
    ovf_exp      = 1'b0;
`endif
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.ifmap_vld = 1'b0; bus.ifmap_in = '0; bus.win_clr = 1'b0;
    bus.w_load = 1'b0; bus.w_in = '0; bus.clr_ovf = 1'b0;
    bus.psum_in_vld = 1'b1; bus.psum_in = 20'd5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_psum",     po(), ps(0));
    check("rst_vld",      32'(bus.psum_out_vld), 32'd0);
    check("rst_w_out",    32'(bus.w_out), 32'd0);
    check("rst_ifmap",    32'(bus.ifmap_out), 32'd0);
    check("rst_ovf",      32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic window: weights {3,-2,1}, samples 10,20,30, psum_in 5 -> 25.
    step(1, 0, 0, 0, 1, W_321, 0);
    check("wload_w_out", 32'(bus.w_out), 32'(W_321));
    step(1, 1, 10, 0, 0, 0, 0);
    check("acc1_vld",   32'(bus.psum_out_vld), 32'd0);
    check("acc1_ifout", 32'(bus.ifmap_out), 32'd10);
    step(1, 1, 20, 0, 0, 0, 0);
    check("acc2_vld",   32'(bus.psum_out_vld), 32'd0);
    step(1, 1, 30, 0, 0, 0, 0);
    check("acc3_vld",   32'(bus.psum_out_vld), 32'd0);
    // win_clr with 40: the 30 result still emerges, new window restarts.
    step(1, 1, 40, 1, 0, 0, 0);
    check("res25_vld",  32'(bus.psum_out_vld), 32'd1);
    check("res25_val",  po(), ps(25));
    step(1, 1, 50, 0, 0, 0, 0);
    check("clr_win1_vld", 32'(bus.psum_out_vld), 32'd0);
    step(1, 1, 60, 0, 0, 0, 0);
    check("clr_win2_vld", 32'(bus.psum_out_vld), 32'd0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("res85_vld",  32'(bus.psum_out_vld), 32'd1);
    check("res85_val",  po(), ps(85));
    step(1, 0, 0, 0, 0, 0, 0);
    check("bubble_vld",  32'(bus.psum_out_vld), 32'd0);
    check("bubble_hold", po(), ps(85));

    // Weight load alongside an accept: 70 uses old weights, 80 uses {1,1,1}.
    step(1, 1, 70, 0, 1, W_111, 0);
    check("wl_acc_vld", 32'(bus.psum_out_vld), 32'd0);
    step(1, 1, 80, 0, 0, 0, 0);
    check("wl_w_out",   32'(bus.w_out), 32'(W_111));
    check("res105_vld", 32'(bus.psum_out_vld), 32'd1);
    check("res105_val", po(), ps(105));
    step(1, 0, 0, 0, 0, 0, 0);
    check("res215_vld", 32'(bus.psum_out_vld), 32'd1);
    check("res215_val", po(), ps(215));
    step(1, 0, 0, 0, 0, 0, 0);
    check("idle_vld",   32'(bus.psum_out_vld), 32'd0);

    // Stall for 3 cycles with the 90 result in flight; junk inputs ignored.
    step(1, 1, 90, 0, 0, 0, 0);
    check("pre_stall_vld", 32'(bus.psum_out_vld), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 200, 1, 1, W_127, 1);
      check("stall_vld",   32'(bus.psum_out_vld), 32'd0);
      check("stall_psum",  po(), ps(215));
      check("stall_ifout", 32'(bus.ifmap_out), 32'd90);
      check("stall_w_out", 32'(bus.w_out), 32'(W_111));
    end
    step(1, 0, 0, 0, 0, 0, 0);
    check("res245_vld", 32'(bus.psum_out_vld), 32'd1);
    check("res245_val", po(), ps(245));
    step(1, 0, 0, 0, 0, 0, 0);
    check("post_stall_vld", 32'(bus.psum_out_vld), 32'd0);

    // Overflow: psum_in 2^19-10, taps 255, weights 127 -> raw sum 621433.
    step(1, 0, 0, 0, 1, W_127, 0);
    bus.psum_in = 20'd524278;
    step(1, 1, 255, 1, 0, 0, 0);
    step(1, 1, 255, 0, 0, 0, 0);
    step(1, 1, 255, 0, 0, 0, 0);
    check("ovf_pre_flag", 32'(bus.ovf), 32'd0);
    step(1, 0, 0, 0, 0, 0, 1);  // clear coincides with new overflow: set wins
    check("ovf_vld",  32'(bus.psum_out_vld), 32'd1);
    check("ovf_psum", po(), ovf_psum_exp);
    check("ovf_flag", 32'(bus.ovf), 32'(ovf_exp));
    step(1, 0, 0, 0, 0, 0, 1);
    check("ovf_clr", 32'(bus.ovf), 32'd0);

    // Asynchronous reset mid-stream with a result in flight.
    bus.psum_in = 20'd5;
    step(1, 1, 10, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_psum",  po(), ps(0));
    check("arst_vld",   32'(bus.psum_out_vld), 32'd0);
    check("arst_w_out", 32'(bus.w_out), 32'd0);
    check("arst_ifout", 32'(bus.ifmap_out), 32'd0);
    check("arst_ovf",   32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 1, W_321, 0);
    check("post_rst_vld0", 32'(bus.psum_out_vld), 32'd0);
    step(1, 1, 10, 0, 0, 0, 0);
    check("post_rst_vld1", 32'(bus.psum_out_vld), 32'd0);
    step(1, 1, 20, 0, 0, 0, 0);
    check("post_rst_vld2", 32'(bus.psum_out_vld), 32'd0);
    step(1, 1, 30, 0, 0, 0, 0);
    check("post_rst_vld3", 32'(bus.psum_out_vld), 32'd0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("post_rst_res_vld", 32'(bus.psum_out_vld), 32'd1);
    check("post_rst_res_val", po(), ps(25));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_conv_param.md
PE_CONV_PARAM -- requirements
Module: pe_conv_param

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DW, 8, ifmap width, unsigned.
- WW, 8, weight width, signed two's complement.
- TAPS, 3, taps per PE; legal range 1..8.
- PW, 20, psum width, signed.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, global advance; low freezes every register.
- ifmap_vld, in, 1, ifmap_in valid.
- ifmap_in, in, DW, unsigned ifmap sample.
- win_clr, in, 1, start of row; clears the window fill count.
- ifmap_out, out, DW, newest tap (tap0), forwarded to the next PE.
- w_load, in, 1, load the weight bus.
- w_in, in, TAPS*WW, weights; slice [k*WW +: WW] belongs to tap k.
- w_out, out, TAPS*WW, registered copy of the active weights.
- psum_in_vld, in, 1, psum_in valid.
- psum_in, in, PW, signed partial sum from the upstream PE.
- psum_out_vld, out, 1, psum_out valid.
- psum_out, out, PW, signed result.
- ovf, out, 1, sticky overflow flag.
- clr_ovf, in, 1, clears ovf.

Function
REQ-003 Accept = en && ifmap_vld; on accept, tap0 <= ifmap_in and tap k <= tap k-1.
REQ-004 Fill counter: 0..TAPS, +1 per accept, saturates at TAPS; window is full when it equals TAPS.
REQ-005 win_clr with en clears the counter; win_clr together with an accept sets the counter to 1; tap contents are never cleared by win_clr.
REQ-006 w_load with en: active weights <= w_in and w_out <= w_in, visible the following cycle.
REQ-007 A sample accepted in the same cycle as w_load uses the old weights.
REQ-008 Stage 1 registers on an accepted sample whose post-accept counter is TAPS:
- each product p_k = zero-extended tap_k (DW+1 bits, signed) × w_k, full precision;
- psum_in, or 0 when psum_in_vld is low;
- a stage-1 valid bit.
REQ-009 Stage 2 registers sum = stage-1 psum + all p_k at PW + clog2(TAPS+1) + 1 bits, then narrows the sum to PW per REQ-017/018.
- psum_out_vld <= stage-1 valid.
REQ-010 Latency: exactly 2 enabled cycles from the accepting edge to psum_out_vld high; throughput is 1 result per accept.
REQ-011 Bubbles: a non-accepting cycle with en high clears the stage-1 valid bit; psum_out holds its last value when its valid is low.
REQ-012 en low: taps, counter, weights, pipeline, valids and ovf all hold; no input is sampled.
REQ-013 Simultaneous clr_ovf and a new overflow: ovf stays 1 (set wins).

Reset
REQ-014 rst_n low forces, asynchronously, these to 0:
- taps, counter, active weights, w_out;
- stage registers, psum_out, psum_out_vld, ovf.
REQ-015 Reset asserted mid-operation discards all in-flight results; after release the first valid output requires TAPS new accepts.
REQ-016 Deassertion is expected synchronous to clk; the block adds no synchroniser.

Configuration
REQ-017 With PE_SATURATE_EN defined, the stage-2 sum clamps to [-2^(PW-1), 2^(PW-1)-1], and any clamp sets ovf.
REQ-018 Without PE_SATURATE_EN, the sum truncates to its PW LSBs (wrap), ovf is tied to 0 and clr_ovf is ignored.

Structure
REQ-019 Package pe_conv_pkg holds:
- the DW/WW/TAPS/PW defaults;
- a localparam for the accumulator width;
- a signed saturate function (input width, output width).
REQ-020 One sub-module, pe_tap_shift, holds the tap shift register and fill counter (REQ-003..005); all arithmetic stays in pe_conv_param.

Verification
REQ-021 Defaults, weights {3,-2,1} (tap2,tap1,tap0), accepts 10,20,30 back-to-back, psum_in=5 valid:
- one result psum_out = 5 + 30·1 + 20·(-2) + 10·3 = 25;
- it appears 2 cycles after the third accept;
- no psum_out_vld after the first two accepts.
REQ-022 win_clr with the 4th accept (value 40): psum_out_vld stays low until two further accepts, then sums taps {40,…} with the new window.
REQ-023 w_load {1,1,1} in the same cycle as an accept: that result still uses {3,-2,1}; the next result uses {1,1,1}.
REQ-024 en low for 3 cycles mid-pipeline: outputs frozen; the result emerges unchanged after en returns, delayed by exactly 3 cycles.
REQ-025 PW=20, psum_in = 2^19-10, taps all 255, weights all 127:
- with PE_SATURATE_EN: psum_out = 524287 and ovf=1;
- without PE_SATURATE_EN: wrapped value and ovf=0.
REQ-026 rst_n pulsed low asynchronously mid-stream: all outputs 0 immediately, and no psum_out_vld until 3 new accepts plus 2 cycles.
